avalon_ram_bridge: RTL and testbench

Avalon-MM slave front end between the CPU data/instruction bus and the word-wide external_ram. Accepts byte-addressed reads and writes with byteenable, translates them to word addresses, and drives the RAM's single-word write port. Partial-word writes are performed as read-modify-write because the RAM has no byte strobes. Stalls the master with waitrequest until each transfer completes.

---
 rtl/avalon_ram_pkg.sv | 27 ++
 rtl/byte_merge.sv | 13 +
 rtl/avalon_ram_bridge.sv | 118 +++++++++++
 tb/tb_avalon_ram_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_ram_pkg.sv
// Shared types and helpers for the Avalon-MM to word-RAM bridge.
// Holds the FSM state encoding, the default window base and the byte-lane merge.
package avalon_ram_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

    // Lanes with byteenable set take the new byte, the rest keep the old one.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] m;
        m = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_word[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane mux used to build the read-modify-write word.
import avalon_ram_pkg::*;

module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    assign merged = merge_bytes(old_word, new_word, be);

endmodule

// File: rtl/avalon_ram_bridge.sv
// Avalon-MM slave that maps a byte-addressed window onto a word-wide RAM,
// doing read-modify-write for partial writes. Optional bus_error: AVALON_RAM_BRIDGE_ERR_EN.
import avalon_ram_pkg::*;

module avalon_ram_bridge #(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
`ifdef AVALON_RAM_BRIDGE_ERR_EN
    output logic        bus_error,
`endif
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    output logic        ram_wen,
    input  logic [31:0] ram_data_out,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_RD   = RD;
    localparam logic [2:0] ST_CAP  = CAP;
    localparam logic [2:0] ST_WR   = WR;
    localparam logic [2:0] ST_DONE = DONE;

    logic [2:0]            state;
    logic [WORDS_LOG2-1:0] idx_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  is_write_q;
    logic [29:0]           off_words;
    logic                  in_window;
    logic [31:0]           merged;

    // Window check uses the untruncated offset so the top word cannot alias.
    assign off_words = 30'((address - BASE_ADDR) >> 2);
    assign in_window = (address >= BASE_ADDR) && ((off_words >> WORDS_LOG2) == 30'd0);

    assign waitrequest = (state != ST_DONE);
    assign ram_wen     = (state == ST_WR);
    assign ram_addr    = {{(32-WORDS_LOG2){1'b0}}, idx_q};
    assign state_dbg   = state;

    byte_merge u_merge (
        .old_word (ram_data_out),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

`ifdef AVALON_RAM_BRIDGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && (read || write)) begin
            err_q <= !in_window || (read && write);
        end
    end

    assign bus_error = (state == ST_DONE) && err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            idx_q          <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            is_write_q     <= 1'b0;
            readdata       <= '0;
            ram_write_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read || write) begin
                        idx_q      <= off_words[WORDS_LOG2-1:0];
                        be_q       <= byteenable;
                        wdata_q    <= writedata;
                        is_write_q <= write;
                        if (!in_window || (write && byteenable == 4'h0)) begin
                            state <= ST_DONE;
                            if (!write) readdata <= '0;
                        end else if (write && byteenable == 4'hF) begin
                            ram_write_data <= writedata;
                            state          <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD:   state <= ST_CAP;
                ST_CAP: begin
                    if (is_write_q) begin
                        ram_write_data <= merged;
                        state          <= ST_WR;
                    end else begin
                        readdata <= ram_data_out;
                        state    <= ST_DONE;
                    end
                end
                ST_WR:   state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_ram_bridge.sv
// Bench for avalon_ram_bridge: directed scenarios plus random transfers checked
// against a word-array reference model and an expected-readdata queue.
import avalon_ram_pkg::*;

module tb_avalon_ram_bridge;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_wen;
    logic [31:0] ram_data_out;
    logic [2:0]  state_dbg;
`ifdef AVALON_RAM_BRIDGE_ERR_EN
    logic        bus_error;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [WORDS];

    // External RAM: synchronous read, one-cycle latency, lazily seeded per word.
    logic [31:0] ram_mem [WORDS];
    logic        ram_vld [WORDS] = '{default: 1'b0};

    function automatic logic [31:0] seed_word(input int i);
        return 32'h1234_5678 ^ (i * 32'h9E37_79B9);
    endfunction

    always @(posedge clk) begin
        if (ram_wen) begin
            ram_mem[ram_addr[9:0]] <= ram_write_data;
            ram_vld[ram_addr[9:0]] <= 1'b1;
        end
        ram_data_out <= ram_vld[ram_addr[9:0]] ? ram_mem[ram_addr[9:0]] : seed_word(int'(ram_addr[9:0]));
    end

    always #5 clk = ~clk;

    avalon_ram_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .read           (read),
        .write          (write),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .readdata       (readdata),
        .waitrequest    (waitrequest),
`ifdef AVALON_RAM_BRIDGE_ERR_EN
        .bus_error      (bus_error),
`endif
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_wen        (ram_wen),
        .ram_data_out   (ram_data_out),
        .state_dbg      (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One Avalon transfer starting at a negedge; hold keeps the request up for
    // a back-to-back follow-on, extra accounts for the DONE->IDLE turnaround.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int extra, input logic hold);
        longint      a;
        logic        inwin;
        int          idx;
        int          lat;
        int          exp_wens;
        logic [31:0] new_word;
        int          n;
        int          wens;
        logic        done;
        logic [31:0] wen_addr;
        logic [31:0] wen_data;

        a     = longint'(addr);
        inwin = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * WORDS);
        idx   = inwin ? int'((a - longint'(BASE)) / 4) : 0;

        if (!inwin)                 lat = 1;
        else if (wr && be == 4'h0)  lat = 1;
        else if (wr && be == 4'hF)  lat = 2;
        else if (wr)                lat = 4;
        else                        lat = 3;

        exp_wens = (wr && inwin && be != 4'h0) ? 1 : 0;
        new_word = ref_mem[idx];
        if (exp_wens == 1) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) new_word[8*i +: 8] = wd[8*i +: 8];
            ref_mem[idx] = new_word;
        end
        if (!wr) exp_q.push_back(inwin ? ref_mem[idx] : 32'h0);

        address = addr; read = rd; write = wr; byteenable = be; writedata = wd;
        n = 0; wens = 0; done = 1'b0; wen_addr = '0; wen_data = '0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
            if (ram_wen) begin
                wens++;
                wen_addr = ram_addr;
                wen_data = ram_write_data;
            end
            if (!waitrequest) done = 1'b1;
        end
        check("completed", 32'(done), 32'd1);
        check("latency", n, lat + extra);
        check("wen_count", wens, exp_wens);
        if (exp_wens == 1) begin
            check("wen_addr", wen_addr, 32'(idx));
            check("wen_data", wen_data, new_word);
        end
        if (!wr) check("readdata", readdata, exp_q.pop_front());
`ifdef AVALON_RAM_BRIDGE_ERR_EN
        check("bus_error", 32'(bus_error), 32'(!inwin || (rd && wr)));
`endif
        if (!hold) begin
            read = 1'b0; write = 1'b0;
            @(negedge clk);
            check("idle_wen", 32'(ram_wen), 32'd0);
        end
    endtask

    initial begin : main
        logic [31:0] addr;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
        logic        b2b;
        int          op;
        int          extra;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
        reset = 1'b0; address = '0; read = 1'b0; write = 1'b0;
        byteenable = '0; writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_wait", 32'(waitrequest), 32'd1);
        check("rst_wen", 32'(ram_wen), 32'd0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_write_data, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Full write then read back.
        xfer(1'b0, 1'b1, 32'hBFC00008, 4'hF, 32'hDEADBEEF, 0, 1'b0);
        xfer(1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0, 0, 1'b0);

        // Partial write as read-modify-write.
        xfer(1'b0, 1'b1, 32'hBFC0000C, 4'hF, 32'h11223344, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'hBFC0000C, 4'b0101, 32'hAABBCCDD, 0, 1'b0);
        xfer(1'b1, 1'b0, 32'hBFC0000C, 4'hF, 32'h0, 0, 1'b0);
        check("rmw_value", ref_mem[3], 32'h11BB33DD);

        // Out of window and byteenable zero.
        xfer(1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'h00001000, 4'hF, 32'h55555555, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'hBFC00008, 4'h0, 32'h77777777, 0, 1'b0);
        xfer(1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0, 0, 1'b0);

        // Window edges.
        xfer(1'b0, 1'b1, BASE + 32'd4092, 4'hF, 32'hCAFEF00D, 0, 1'b0);
        xfer(1'b1, 1'b0, BASE + 32'd4095, 4'hF, 32'h0, 0, 1'b0);
        xfer(1'b1, 1'b0, BASE + 32'd4096, 4'hF, 32'h0, 0, 1'b0);
        xfer(1'b1, 1'b0, BASE - 32'd1, 4'hF, 32'h0, 0, 1'b0);
        xfer(1'b1, 1'b1, 32'hBFC00010, 4'hF, 32'h0BADC0DE, 0, 1'b0);

        // Reset while the RMW sits in CAP: transfer dropped, RAM untouched.
        address = 32'hBFC00014; write = 1'b1; byteenable = 4'b0011; writedata = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        check("rmw_in_cap", 32'(state_dbg), 32'(CAP));
        reset = 1'b0;
        #1;
        check("rst_idle", 32'(state_dbg), 32'(IDLE));
        check("rst_mid_wait", 32'(waitrequest), 32'd1);
        check("rst_mid_wen", 32'(ram_wen), 32'd0);
        write = 1'b0;
        @(negedge clk);
        check("rst_hold_wen", 32'(ram_wen), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        xfer(1'b1, 1'b0, 32'hBFC00014, 4'hF, 32'h0, 0, 1'b0);
        xfer(1'b0, 1'b1, 32'hBFC00014, 4'b0011, 32'hFFFFFFFF, 0, 1'b0);
        xfer(1'b1, 1'b0, 32'hBFC00014, 4'hF, 32'h0, 0, 1'b0);

        // Back-to-back reads of four consecutive words.
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, (i == 0) ? 0 : 1, i != 3);

        // Random mix.
        extra = 0;
        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 9))
                0:       addr = BASE + 32'd4092 + 32'($urandom_range(0, 7));
                1:       addr = BASE - 32'($urandom_range(1, 8));
                2:       addr = $urandom;
                default: addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            op = $urandom_range(0, 9);
            rd = (op < 4) || (op == 9);
            wr = (op >= 4);
            be = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            b2b = ($urandom_range(0, 3) == 0);
            xfer(rd, wr, addr, be, $urandom, extra, b2b);
            extra = b2b ? 1 : 0;
        end
        if (extra == 1) begin
            read = 1'b0; write = 1'b0;
            @(negedge clk);
        end

        // Final sweep of the touched region against the reference model.
        for (int i = 0; i < 16; i++)
            xfer(1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, 0, 1'b0);
        xfer(1'b1, 1'b0, BASE + 32'd4092, 4'hF, 32'h0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
